// File: rtl/ysyx_lsu_sram_pkg.sv
// Shared encodings and helpers for the LSU-side data SRAM responder.
// Size strobes match the LSU encoding; LAT_DEFAULT is the default response latency.
package ysyx_lsu_sram_pkg;

   localparam logic [7:0] STRB_B = 8'h01;
   localparam logic [7:0] STRB_H = 8'h03;
   localparam logic [7:0] STRB_W = 8'h0f;

   localparam int LAT_DEFAULT = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      HOLD    = 2'd3
   } lsu_state_t;

   function automatic logic [31:0] byte_mask(input logic [3:0] be);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) begin
         m[8*i +: 8] = {8{be[i]}};
      end
      return m;
   endfunction

   // Byte accesses never misalign; halves may not straddle the word, words must be aligned.
   function automatic logic misaligned(input logic [3:0] strb, input logic [1:0] off);
      return ((strb == STRB_H[3:0]) && (off == 2'd3)) ||
             ((strb == STRB_W[3:0]) && (off != 2'd0));
   endfunction

endpackage

// File: rtl/ysyx_lsu_sram_bank.sv
// Single-port word SRAM with per-byte write enables.
// Write is synchronous, read is combinational from the current address.
module ysyx_sram_bank #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we && be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/ysyx_lsu_sram.sv
// LSU data-memory responder: one load or store at a time, fixed LAT-cycle response,
// range/alignment checking and sub-word lane shifting in front of a word SRAM.
module ysyx_lsu_sram
   import ysyx_lsu_sram_pkg::*;
#(
   parameter int               ADDR_W = 32,
   parameter int               DATA_W = 32,
   parameter int               DEPTH  = 1024,
   parameter logic [ADDR_W-1:0] BASE  = 'h8000_0000,
   parameter int               LAT    = LAT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] lsu_araddr,
   input  logic              lsu_arvalid,
   input  logic [7:0]        lsu_rstrb,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              lsu_rvalid,
   input  logic [ADDR_W-1:0] lsu_awaddr,
   input  logic              lsu_awvalid,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [7:0]        lsu_wstrb,
   input  logic              lsu_wvalid,
   output logic              lsu_wready,
   output logic              err_o
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   lsu_state_t        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              ld_req, st_req, resp;

   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        strb_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;

   logic [ADDR_W-1:0] rel, idx_full;
   logic [1:0]        off;
   logic              in_range, mis, acc_ok;
   logic              resp_live, resp_rd, resp_wr;
   logic [3:0]        bank_be;
   logic [DATA_W-1:0] bank_wdata, bank_rdata, rd_val;

   // Only 8/16/32-bit sizes exist, so the upper strobe bits carry no information.
   logic unused_strb_hi;
   assign unused_strb_hi = ^{lsu_rstrb[7:4], lsu_wstrb[7:4]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ld_req  = 1'b0;
      st_req  = 1'b0;
      resp    = 1'b0;
      case (state_q)
         IDLE: begin
            if (lsu_arvalid) begin
               ld_req  = 1'b1;
               cnt_d   = CNT_INIT;
               state_d = RD_WAIT;
            end else if (lsu_awvalid && lsu_wvalid) begin
               st_req  = 1'b1;
               cnt_d   = CNT_INIT;
               state_d = WR_WAIT;
            end
         end
         RD_WAIT, WR_WAIT: begin
            if (cnt_q == 4'd0) begin
               resp    = 1'b1;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         HOLD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (resp_rd) begin
            rdata_q <= rd_val;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (ld_req) begin
         addr_q <= lsu_araddr;
         strb_q <= lsu_rstrb[3:0];
      end else if (st_req) begin
         addr_q  <= lsu_awaddr;
         strb_q  <= lsu_wstrb[3:0];
         wdata_q <= lsu_wdata;
      end
   end

   // Subtraction wraps in ADDR_W bits, so addresses below BASE land far out of range.
   assign rel      = addr_q - BASE;
   assign idx_full = rel >> 2;
   assign in_range = (addr_q >= BASE) && (idx_full < ADDR_W'(DEPTH));
   assign off      = addr_q[1:0];
   assign mis      = misaligned(strb_q, off);
   assign acc_ok   = in_range && !mis;

   // A reset arriving in the response cycle suppresses both the pulse and the write.
   assign resp_live = resp && !rst;
   assign resp_rd   = resp_live && (state_q == RD_WAIT);
   assign resp_wr   = resp_live && (state_q == WR_WAIT);

   assign bank_be    = strb_q << off;
   assign bank_wdata = wdata_q << {off, 3'b000};

   ysyx_sram_bank #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_bank (
      .clk   (clk),
      .addr  (idx_full[AW-1:0]),
      .we    (resp_wr && acc_ok),
      .be    (bank_be),
      .wdata (bank_wdata),
      .rdata (bank_rdata)
   );

   assign rd_val = acc_ok ? ((bank_rdata >> {off, 3'b000}) & byte_mask(strb_q)) : '0;

   assign lsu_rvalid = resp_rd;
   assign lsu_wready = resp_wr;
   assign err_o      = resp_live && !acc_ok;
   assign lsu_rdata  = resp_rd ? rd_val : rdata_q;

endmodule

// File: tb/tb_ysyx_lsu_sram.sv
// Directed bench for ysyx_lsu_sram: a vector table of loads/stores with hand-computed
// results, followed by hand-written collision, reset-abort and held-valid sequences.
module tb_ysyx_lsu_sram;

   localparam int          LAT   = 2;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] B     = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] araddr, awaddr, wdata, rdata;
   logic        arvalid, awvalid, wvalid, rvalid, wready, err;
   logic [7:0]  rstrb, wstrb;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ysyx_lsu_sram #(
      .ADDR_W (32),
      .DATA_W (32),
      .DEPTH  (DEPTH),
      .BASE   (B),
      .LAT    (LAT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .lsu_araddr  (araddr),
      .lsu_arvalid (arvalid),
      .lsu_rstrb   (rstrb),
      .lsu_rdata   (rdata),
      .lsu_rvalid  (rvalid),
      .lsu_awaddr  (awaddr),
      .lsu_awvalid (awvalid),
      .lsu_wdata   (wdata),
      .lsu_wstrb   (wstrb),
      .lsu_wvalid  (wvalid),
      .lsu_wready  (wready),
      .err_o       (err)
   );

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [7:0]  strb;
      logic [31:0] wdata;
      logic [31:0] exp_d;
      bit          exp_e;
   } vec_t;

   vec_t v[29];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Leaves the bench in an IDLE cycle: response, then HOLD, then IDLE.
   task automatic do_load(input logic [31:0] a, input logic [7:0] s,
                          output logic [31:0] d, output logic e, output int lat);
      araddr  = a;
      rstrb   = s;
      arvalid = 1'b1;
      lat = -1; d = '0; e = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         if (rvalid) begin
            lat = k; d = rdata; e = err;
            break;
         end
      end
      arvalid = 1'b0;
      cyc();
      cyc();
   endtask

   task automatic do_store(input logic [31:0] a, input logic [7:0] s, input logic [31:0] dat,
                           output logic e, output int lat);
      awaddr  = a;
      wstrb   = s;
      wdata   = dat;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      lat = -1; e = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         if (wready) begin
            lat = k; e = err;
            break;
         end
      end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      cyc();
      cyc();
   endtask

   initial begin
      logic [31:0] d;
      logic        e;
      int          lat, r_k, w_k, cnt;

      v[0]  = '{1'b1, B + 32'd4,    8'h0f, 32'hdeadbeef, 32'h0,        1'b0};
      v[1]  = '{1'b0, B + 32'd4,    8'h0f, 32'h0,        32'hdeadbeef, 1'b0};
      v[2]  = '{1'b1, B + 32'd4,    8'h0f, 32'h11223344, 32'h0,        1'b0};
      v[3]  = '{1'b1, B + 32'd7,    8'h01, 32'h000000aa, 32'h0,        1'b0};
      v[4]  = '{1'b0, B + 32'd4,    8'h0f, 32'h0,        32'haa223344, 1'b0};
      v[5]  = '{1'b0, B + 32'd7,    8'h01, 32'h0,        32'h000000aa, 1'b0};
      v[6]  = '{1'b0, B + 32'd6,    8'h03, 32'h0,        32'h0000aa22, 1'b0};
      v[7]  = '{1'b0, B + 32'd4,    8'h01, 32'h0,        32'h00000044, 1'b0};
      v[8]  = '{1'b1, B,            8'h0f, 32'h01020304, 32'h0,        1'b0};
      v[9]  = '{1'b1, B + 32'd4092, 8'h0f, 32'hcafef00d, 32'h0,        1'b0};
      v[10] = '{1'b1, B + 32'd12,   8'h0f, 32'h00000000, 32'h0,        1'b0};
      v[11] = '{1'b0, B + 32'd4096, 8'h0f, 32'h0,        32'h0,        1'b1};
      v[12] = '{1'b0, B - 32'd4,    8'h0f, 32'h0,        32'h0,        1'b1};
      v[13] = '{1'b1, B + 32'd4096, 8'h0f, 32'h55555555, 32'h0,        1'b1};
      v[14] = '{1'b1, B - 32'd4,    8'h0f, 32'h66666666, 32'h0,        1'b1};
      v[15] = '{1'b0, B,            8'h0f, 32'h0,        32'h01020304, 1'b0};
      v[16] = '{1'b0, B + 32'd4092, 8'h0f, 32'h0,        32'hcafef00d, 1'b0};
      v[17] = '{1'b0, B + 32'd2,    8'h0f, 32'h0,        32'h0,        1'b1};
      v[18] = '{1'b0, B + 32'd3,    8'h03, 32'h0,        32'h0,        1'b1};
      v[19] = '{1'b0, B + 32'd2,    8'h03, 32'h0,        32'h00000102, 1'b0};
      v[20] = '{1'b1, B + 32'd2,    8'h0f, 32'h77777777, 32'h0,        1'b1};
      v[21] = '{1'b0, B,            8'h0f, 32'h0,        32'h01020304, 1'b0};
      v[22] = '{1'b1, B + 32'd2,    8'h03, 32'h0000beef, 32'h0,        1'b0};
      v[23] = '{1'b0, B,            8'h0f, 32'h0,        32'hbeef0304, 1'b0};
      v[24] = '{1'b1, B + 32'd1,    8'h01, 32'h00000077, 32'h0,        1'b0};
      v[25] = '{1'b0, B + 32'd1,    8'h01, 32'h0,        32'h00000077, 1'b0};
      v[26] = '{1'b0, B,            8'h0f, 32'h0,        32'hbeef7704, 1'b0};
      v[27] = '{1'b0, B + 32'd5,    8'h03, 32'h0,        32'h00002233, 1'b0};
      v[28] = '{1'b0, B + 32'd3,    8'h01, 32'h0,        32'h000000be, 1'b0};

      rst = 1'b1;
      araddr = '0; awaddr = '0; wdata = '0;
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      rstrb = 8'h0; wstrb = 8'h0;
      repeat (3) cyc();
      rst = 1'b0;
      cyc();
      check("reset_rvalid", {31'd0, rvalid}, 32'd0);
      check("reset_wready", {31'd0, wready}, 32'd0);
      check("reset_err",    {31'd0, err},    32'd0);
      check("reset_rdata",  rdata,           32'd0);

      foreach (v[i]) begin
         if (v[i].wr) begin
            do_store(v[i].addr, v[i].strb, v[i].wdata, e, lat);
            check($sformatf("vec%0d_st_lat", i), lat, LAT);
            check($sformatf("vec%0d_st_err", i), {31'd0, e}, {31'd0, v[i].exp_e});
         end else begin
            do_load(v[i].addr, v[i].strb, d, e, lat);
            check($sformatf("vec%0d_ld_lat", i), lat, LAT);
            check($sformatf("vec%0d_ld_err", i), {31'd0, e}, {31'd0, v[i].exp_e});
            check($sformatf("vec%0d_ld_data", i), d, v[i].exp_d);
         end
      end

      // rdata keeps the last load result (v[28]) while rvalid is low
      check("rdata_hold", rdata, 32'h000000be);

      // Load and store presented together: load first, store after HOLD + IDLE accept
      araddr = B + 32'd4; rstrb = 8'h0f; arvalid = 1'b1;
      awaddr = B + 32'd8; wstrb = 8'h0f; wdata = 32'h12345678;
      awvalid = 1'b1; wvalid = 1'b1;
      r_k = -1; w_k = -1; d = '0;
      for (int k = 1; k <= 30; k++) begin
         cyc();
         if (rvalid && r_k < 0) begin
            r_k = k; d = rdata; arvalid = 1'b0;
         end
         if (wready) begin
            w_k = k; awvalid = 1'b0; wvalid = 1'b0;
            break;
         end
      end
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      cyc();
      cyc();
      check("coll_rd_lat",  r_k,  LAT);
      check("coll_rd_data", d,    32'haa223344);
      check("coll_wr_lat",  w_k,  LAT + 2 + LAT);
      do_load(B + 32'd8, 8'h0f, d, e, lat);
      check("coll_wr_result", d, 32'h12345678);

      // Reset during RD_WAIT: no response for 2*LAT cycles
      araddr = B + 32'd4; rstrb = 8'h0f; arvalid = 1'b1;
      cyc();
      rst = 1'b1; arvalid = 1'b0;
      cyc();
      rst = 1'b0;
      cnt = 0;
      for (int k = 0; k < 2 * LAT; k++) begin
         if (rvalid) cnt++;
         cyc();
      end
      check("rst_rd_no_rvalid", cnt, 0);
      do_load(B + 32'd4, 8'h0f, d, e, lat);
      check("post_rst_lat",  lat, LAT);
      check("post_rst_data", d,   32'haa223344);

      // Reset during WR_WAIT: the store is abandoned and memory keeps its old word
      awaddr = B + 32'd12; wstrb = 8'h0f; wdata = 32'hffffffff;
      awvalid = 1'b1; wvalid = 1'b1;
      cyc();
      rst = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
      cyc();
      rst = 1'b0;
      cnt = 0;
      for (int k = 0; k < 2 * LAT; k++) begin
         if (wready) cnt++;
         cyc();
      end
      check("rst_wr_no_wready", cnt, 0);
      do_load(B + 32'd12, 8'h0f, d, e, lat);
      check("rst_wr_not_done", d, 32'h00000000);

      // arvalid held through the whole HOLD cycle is still accepted exactly once
      araddr = B + 32'd4; rstrb = 8'h0f; arvalid = 1'b1;
      cnt = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         if (k == LAT + 2) arvalid = 1'b0;
         @(negedge clk);
         if (rvalid) cnt++;
      end
      arvalid = 1'b0;
      check("hold_single_accept", cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
